// File: rtl/shift_sequencer_if.sv
// Control bus between the shift sequencer and the external parallel-load shifter.
// The sequencer drives load/shift controls and reads back the shifter's parallel output.
interface shift_sequencer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] sh_load_val;
   logic             sh_load_n;
   logic             sh_shift_right;
   logic             sh_asr;

   modport master (
      input  sh_q,
      output sh_load_val, sh_load_n, sh_shift_right, sh_asr
   );

   modport slave (
      output sh_q,
      input  sh_load_val, sh_load_n, sh_shift_right, sh_asr
   );
endinterface

// File: rtl/shift_sequencer.sv
// Moore FSM sequencing an external right shifter: load, shift n times, capture, pulse done.
// Outputs are registered and updated alongside the state on each transition.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [WIDTH-1:0]    data_in,
   input  logic [AMT_W-1:0]    shift_amt,
   input  logic                arith,
   shift_sequencer_if.master   sh,
   output logic                busy,
   output logic                done,
   output logic [WIDTH-1:0]    result
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      CAPTURE,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_q;
   logic [AMT_W-1:0] cnt_q;
   logic             load_n_q;
   logic             shr_q;
   logic             asr_q;

   assign sh.sh_load_val    = op_q;
   assign sh.sh_load_n      = load_n_q;
   assign sh.sh_shift_right = shr_q;
   assign sh.sh_asr         = asr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         load_n_q <= 1'b1;
         shr_q    <= 1'b0;
         asr_q    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else if (abort && (state == LOAD || state == SHIFT || state == CAPTURE)) begin
         // Cancel: controls return to idle values, result untouched, no done pulse.
         state    <= IDLE;
         load_n_q <= 1'b1;
         shr_q    <= 1'b0;
         asr_q    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q     <= data_in;
                  cnt_q    <= shift_amt;
                  asr_q    <= arith;
                  load_n_q <= 1'b0;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               load_n_q <= 1'b1;
               if (cnt_q != '0) begin
                  shr_q <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= CAPTURE;
               end
            end
            SHIFT: begin
               // Leaving when the counter reads 1 gives exactly cnt SHIFT cycles.
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == AMT_W'(1)) begin
                  shr_q <= 1'b0;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               result <= sh.sh_q;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               asr_q <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               load_n_q <= 1'b1;
               shr_q    <= 1'b0;
               asr_q    <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
